// File: rtl/dialysis_session_sequencer.sv
// Session-level sequencer for hemodialysis_fsm: prime, start, treat, stop, rinse-back.
// Optional macro WARN_PAUSE_EN: treatment time does not accrue while fsm_alarm_warning is high.
module dialysis_session_sequencer #(
  parameter int PRIME_CYCLES = 16,
  parameter int TREAT_CYCLES = 64,
  parameter int RINSE_CYCLES = 8,
  parameter int ACK_TIMEOUT  = 8,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             session_go,
  input  logic             session_abort,
  input  logic             fsm_pump_on,
  input  logic             fsm_alarm_warning,
  input  logic             fsm_alarm_emergency,
  output logic             start_cmd,
  output logic             stop_cmd,
  output logic             prime_valve_open,
  output logic             rinse_valve_open,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] treat_elapsed,
  output logic             session_done,
  output logic             session_fault
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRIME = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_TREAT = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_RINSE = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_FAULT = 3'd7;

  localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(PRIME_CYCLES - 1);
  localparam logic [CNT_W-1:0] RINSE_LAST = CNT_W'(RINSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TREAT_LAST = CNT_W'(TREAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TREAT_FULL = CNT_W'(TREAT_CYCLES);

  logic [2:0]       nxt;
  logic [CNT_W-1:0] cnt;
  logic             te_inc, te_clr, qual;

`ifdef WARN_PAUSE_EN
  assign qual = fsm_pump_on && !fsm_alarm_warning;
`else
  logic unused_warn;
  assign unused_warn = fsm_alarm_warning;
  assign qual        = fsm_pump_on;
`endif

  // Each branch is ordered emergency > abort > ack/timeout > expiry.
  always_comb begin
    nxt    = phase;
    te_inc = 1'b0;
    te_clr = 1'b0;
    case (phase)
      S_IDLE, S_DONE:
        if (session_go) begin
          nxt    = S_PRIME;
          te_clr = 1'b1;
        end
      S_PRIME:
        if (fsm_alarm_emergency)   nxt = S_FAULT;
        else if (session_abort)    nxt = S_IDLE;
        else if (cnt == PRIME_LAST) nxt = S_START;
      S_START:
        if (fsm_alarm_emergency)   nxt = S_FAULT;
        else if (fsm_pump_on)      nxt = S_TREAT;
        else if (cnt == ACK_LAST)  nxt = S_FAULT;
      S_TREAT:
        if (fsm_alarm_emergency)   nxt = S_FAULT;
        else if (session_abort)    nxt = S_STOP;
        else if (!fsm_pump_on)     nxt = S_FAULT;
        else if (qual && treat_elapsed != TREAT_FULL) begin
          te_inc = 1'b1;
          if (treat_elapsed == TREAT_LAST) nxt = S_STOP;
        end
      S_STOP:
        // The pump cannot have reacted yet on the stop_cmd pulse cycle.
        if (fsm_alarm_emergency)                nxt = S_FAULT;
        else if (cnt != '0 && !fsm_pump_on)     nxt = S_RINSE;
        else if (cnt == ACK_LAST)               nxt = S_FAULT;
      S_RINSE:
        if (fsm_alarm_emergency)   nxt = S_FAULT;
        else if (cnt == RINSE_LAST) nxt = S_DONE;
      default: nxt = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase            <= S_IDLE;
      cnt              <= '0;
      treat_elapsed    <= '0;
      start_cmd        <= 1'b0;
      stop_cmd         <= 1'b0;
      prime_valve_open <= 1'b0;
      rinse_valve_open <= 1'b0;
      session_done     <= 1'b0;
      session_fault    <= 1'b0;
    end else begin
      phase <= nxt;
      if (nxt != phase)   cnt <= '0;
      else if (cnt != '1) cnt <= cnt + 1'b1;
      if (te_clr)         treat_elapsed <= '0;
      else if (te_inc)    treat_elapsed <= treat_elapsed + 1'b1;
      // Outputs decode the next state so they line up with phase.
      start_cmd        <= (nxt == S_START) && (phase != S_START);
      stop_cmd         <= (nxt != phase) && (nxt == S_STOP || nxt == S_FAULT);
      prime_valve_open <= (nxt == S_PRIME);
      rinse_valve_open <= (nxt == S_RINSE);
      session_done     <= (nxt == S_DONE);
      session_fault    <= (nxt == S_FAULT);
    end
  end

endmodule

// File: tb/tb_dialysis_session_sequencer.sv
// Bench for dialysis_session_sequencer: directed test-plan scenarios plus randomized sessions,
// every cycle compared against a behavioural session model.
module tb_dialysis_session_sequencer;
  localparam int P = 4, T = 10, R = 3, A = 5, W = 16;

  logic clk = 1'b0, reset = 1'b1;
  logic go = 0, abort = 0, pump = 0, warn = 0, emg = 0;
  logic start_cmd, stop_cmd, prime_valve_open, rinse_valve_open, session_done, session_fault;
  logic [2:0] phase;
  logic [W-1:0] treat_elapsed;

  int checks = 0, passes = 0;

  dialysis_session_sequencer #(.PRIME_CYCLES(P), .TREAT_CYCLES(T), .RINSE_CYCLES(R),
                               .ACK_TIMEOUT(A), .CNT_W(W)) dut (
    .clk(clk), .reset(reset), .session_go(go), .session_abort(abort),
    .fsm_pump_on(pump), .fsm_alarm_warning(warn), .fsm_alarm_emergency(emg),
    .start_cmd(start_cmd), .stop_cmd(stop_cmd), .prime_valve_open(prime_valve_open),
    .rinse_valve_open(rinse_valve_open), .phase(phase), .treat_elapsed(treat_elapsed),
    .session_done(session_done), .session_fault(session_fault));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
  endtask

  function automatic logic [24:0] outs();
    return {phase, start_cmd, stop_cmd, prime_valve_open, rinse_valve_open,
            session_done, session_fault, treat_elapsed};
  endfunction

  // Behavioural model: phase number, cycles spent in it, therapy cycles accrued.
  int m_ph = 0, m_t = 0, m_te = 0;
  always @(posedge clk or posedge reset) begin
    int nx;
    bit q;
    if (reset) begin
      m_ph = 0; m_t = 0; m_te = 0;
    end else begin
      nx = m_ph;
`ifdef WARN_PAUSE_EN
      q = pump && !warn;
`else
      q = pump;
`endif
      if (m_ph >= 1 && m_ph <= 5 && emg) nx = 7;
      else if ((m_ph == 0 || m_ph == 6) && go) begin nx = 1; m_te = 0; end
      else if (m_ph == 1) nx = abort ? 0 : (m_t == P - 1) ? 2 : 1;
      else if (m_ph == 2) nx = pump ? 3 : (m_t == A - 1) ? 7 : 2;
      else if (m_ph == 3) begin
        if (abort) nx = 4;
        else if (!pump) nx = 7;
        else if (q && m_te < T) begin m_te++; if (m_te == T) nx = 4; end
      end
      else if (m_ph == 4) nx = (m_t > 0 && !pump) ? 5 : (m_t == A - 1) ? 7 : 4;
      else if (m_ph == 5) nx = (m_t == R - 1) ? 6 : 5;
      m_t  = (nx == m_ph) ? m_t + 1 : 0;
      m_ph = nx;
    end
  end

  always @(negedge clk) if (!reset) begin
    logic [24:0] e;
    e = {3'(m_ph), m_ph == 2 && m_t == 0, (m_ph == 4 || m_ph == 7) && m_t == 0,
         m_ph == 1, m_ph == 5, m_ph == 6, m_ph == 7, 16'(m_te)};
    chk("cycle_vs_model", 32'(outs()), 32'(e));
  end

  // Pump plant: rises on_dly cycles after start_cmd, falls off_dly cycles after stop_cmd.
  int on_dly = 2, off_dly = 1, on_cnt = 0, off_cnt = 0;
  bit on_pend = 0, off_pend = 0, glitch_en = 0;
  always begin
    @(posedge clk); #1;
    if (reset) begin
      pump = 0; on_pend = 0; off_pend = 0;
    end else begin
      if (start_cmd) begin on_pend = 1; on_cnt = 0; end
      if (stop_cmd) begin off_pend = 1; off_cnt = 0; on_pend = 0; end
      if (on_pend) begin
        if (on_cnt >= on_dly) begin pump = 1; on_pend = 0; end else on_cnt++;
      end
      if (off_pend) begin
        if (off_cnt >= off_dly) begin pump = 0; off_pend = 0; end else off_cnt++;
      end
      if (glitch_en && pump && !off_pend && $urandom % 80 == 0) pump = 0;
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic do_reset();
    reset = 1; go = 0; abort = 0; warn = 0; emg = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(outs()), 32'd0);
    reset = 0;
  endtask

  task automatic begin_session();
    go = 1; tick(); go = 0;
  endtask

  task automatic count_phase(input logic [2:0] p, output int n);
    n = 0;
    while (phase == p && n < 200) begin tick(); n++; end
  endtask

  task automatic wait_te(input int v);
    int n = 0;
    while (treat_elapsed != W'(v) && n < 100) begin tick(); n++; end
    chk("wait_treat_elapsed", 32'(treat_elapsed), 32'(v));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    // Nominal session
    on_dly = 2; off_dly = 1;
    do_reset();
    begin_session();
    chk("nom_prime_entry", {phase, prime_valve_open}, {3'd1, 1'b1});
    count_phase(3'd1, n);  chk("nom_prime_len", n, P);
    chk("nom_start_entry", {phase, start_cmd, prime_valve_open}, {3'd2, 1'b1, 1'b0});
    count_phase(3'd2, n);  chk("nom_start_len", n, 3);
    chk("nom_treat_entry", phase, 3);
    count_phase(3'd3, n);  chk("nom_treat_len", n, T);
    chk("nom_stop_entry", {phase, stop_cmd, treat_elapsed}, {3'd4, 1'b1, 16'd10});
    count_phase(3'd4, n);  chk("nom_stop_len", n, 2);
    chk("nom_rinse_entry", {phase, rinse_valve_open}, {3'd5, 1'b1});
    count_phase(3'd5, n);  chk("nom_rinse_len", n, R);
    chk("nom_done", {phase, session_done, rinse_valve_open, treat_elapsed},
        {3'd6, 1'b1, 1'b0, 16'd10});

    // Start timeout
    on_dly = 1000;
    do_reset();
    begin_session();
    count_phase(3'd1, n);
    chk("to_start_pulse", {phase, start_cmd}, {3'd2, 1'b1});
    count_phase(3'd2, n);  chk("to_start_len", n, A);
    chk("to_fault_entry", {phase, session_fault, stop_cmd}, {3'd7, 1'b1, 1'b1});
    go = 1; tick(); tick(); go = 0;
    chk("to_fault_held", {phase, session_fault, stop_cmd}, {3'd7, 1'b1, 1'b0});

    // Emergency and abort together at treat_elapsed=6
    on_dly = 2;
    do_reset();
    begin_session();
    wait_te(6);
    emg = 1; abort = 1; tick(); emg = 0; abort = 0;
    chk("emg_fault", {phase, stop_cmd, treat_elapsed}, {3'd7, 1'b1, 16'd6});

    // Abort at treat_elapsed=3
    do_reset();
    begin_session();
    wait_te(3);
    abort = 1; tick(); abort = 0;
    chk("abort_stop", {phase, stop_cmd, treat_elapsed}, {3'd4, 1'b1, 16'd3});
    count_phase(3'd4, n);
    count_phase(3'd5, n);  chk("abort_rinse_len", n, R);
    chk("abort_done", {phase, session_done, treat_elapsed}, {3'd6, 1'b1, 16'd3});

    // Warning high for 4 TREAT cycles
    do_reset();
    begin_session();
    count_phase(3'd1, n);
    count_phase(3'd2, n);
    n = 0;
    while (phase == 3'd3 && n < 100) begin warn = (n >= 2 && n < 6); tick(); n++; end
    warn = 0;
`ifdef WARN_PAUSE_EN
    chk("warn_treat_len", n, T + 4);
`else
    chk("warn_treat_len", n, T);
`endif

    // Asynchronous reset mid-RINSE
    do_reset();
    begin_session();
    for (int s = 1; s <= 4; s++) count_phase(3'(s), n);
    tick();
    chk("ar_in_rinse", {phase, rinse_valve_open}, {3'd5, 1'b1});
    #2 reset = 1;
    #1 chk("async_reset", 32'(outs()), 32'd0);
    @(posedge clk); #1 reset = 0;

    // Randomized sessions
    glitch_en = 1;
    for (int it = 0; it < 40; it++) begin
      on_dly  = $urandom_range(0, 6);
      off_dly = $urandom_range(0, 6);
      do_reset();
      for (int c = 0; c < 100; c++) begin
        go    = ($urandom % 4 == 0);
        abort = ($urandom % 40 == 0);
        emg   = ($urandom % 200 == 0);
        warn  = ($urandom % 6 == 0);
        tick();
      end
    end
    go = 0; abort = 0; emg = 0; warn = 0;
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
